capture_sequencer: RTL

- clk-domain controller that sequences the logic-capture core through arm -> trigger -> done -> drain for one or more segmented acquisitions.
- Drives the core's arm/abort, applies a trigger timeout, and computes the ring-buffer unwrap address of each segment's oldest sample.
- Issues one DMA read request per segment, then raises a completion interrupt.
- Core status inputs (ready, armed, triggered, done, trigger_pos) arrive already synchronised to clk by an external 2-FF stage.

---
 rtl/capture_sequencer_if.sv | 26 ++
 rtl/capture_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer_if.sv
// Capture-core and DMA handshake bundle. The sequencer uses master; the core/DMA side uses slave.
interface capture_sequencer_if #(
    parameter int saddr_w = 24
);
    logic               cap_ready;
    logic               cap_armed;
    logic               cap_triggered;
    logic               cap_done;
    logic [saddr_w-1:0] cap_trigger_pos;
    logic               cap_arm;
    logic               cap_abort;
    logic               dma_start;
    logic [saddr_w-1:0] dma_addr;
    logic [saddr_w-1:0] dma_len;
    logic               dma_busy;

    modport master (
        input  cap_ready, cap_armed, cap_triggered, cap_done, cap_trigger_pos, dma_busy,
        output cap_arm, cap_abort, dma_start, dma_addr, dma_len
    );

    modport slave (
        output cap_ready, cap_armed, cap_triggered, cap_done, cap_trigger_pos, dma_busy,
        input  cap_arm, cap_abort, dma_start, dma_addr, dma_len
    );
endinterface

// File: rtl/capture_sequencer.sv
// Sequences the logic-capture core through arm/trigger/done/drain for segmented acquisitions.
//   state      | meaning
//   IDLE       | no run; waiting for start
//   WAIT_READY | waiting for core idle
//   ARM        | cap_arm held until core reports armed
//   WAIT_TRIG  | armed, waiting for trigger under optional timeout
//   WAIT_DONE  | triggered, waiting for post-trigger capture
//   DRAIN_REQ  | waiting for DMA idle, then issue dma_start
//   DRAIN_WAIT | DMA transfer in flight; stop is deferred
//   NEXT       | advance segment or finish the run
//   ABORT      | cap_abort held until core ready or 64 cycles
module capture_sequencer #(
    parameter int saddr_w = 24,
    parameter int seg_w   = 8,
    parameter int tmo_w   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [seg_w-1:0]   num_segments,
    input  logic [tmo_w-1:0]   timeout_cycles,
    input  logic [saddr_w-1:0] buffer_size,
    input  logic [saddr_w-1:0] post_trigger_count,
    capture_sequencer_if.master bus,
    output logic               busy,
    output logic [seg_w-1:0]   seg_index,
    output logic               status_timeout,
    output logic               status_aborted,
    output logic               irq
);
    typedef enum logic [3:0] {
        IDLE, WAIT_READY, ARM, WAIT_TRIG, WAIT_DONE,
        DRAIN_REQ, DRAIN_WAIT, NEXT, ABORT
    } state_t;

    state_t             state;
    logic [seg_w-1:0]   seg_last;
    logic [saddr_w-1:0] buf_lat;
    logic [saddr_w-1:0] post_lat;
    logic [tmo_w-1:0]   tmo_cnt;
    logic [5:0]         abort_cnt;
    logic               stop_pend;
    logic [saddr_w:0]   sum;
    logic [saddr_w-1:0] next_addr;

    // One extra bit so trigger_pos + post never overflows before the wrap compare.
    always_comb begin
        sum       = {1'b0, bus.cap_trigger_pos} + {1'b0, post_lat};
        next_addr = sum[saddr_w-1:0];
        if (sum >= {1'b0, buf_lat})
            next_addr = saddr_w'(sum - {1'b0, buf_lat});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            seg_last       <= '0;
            buf_lat        <= '0;
            post_lat       <= '0;
            tmo_cnt        <= '0;
            abort_cnt      <= '0;
            stop_pend      <= 1'b0;
            bus.cap_arm    <= 1'b0;
            bus.cap_abort  <= 1'b0;
            bus.dma_start  <= 1'b0;
            bus.dma_addr   <= '0;
            bus.dma_len    <= '0;
            busy           <= 1'b0;
            seg_index      <= '0;
            status_timeout <= 1'b0;
            status_aborted <= 1'b0;
            irq            <= 1'b0;
        end else begin
            bus.dma_start <= 1'b0;
            irq           <= 1'b0;
            if (stop && state != IDLE && state != DRAIN_WAIT && state != ABORT) begin
                status_aborted <= 1'b1;
                bus.cap_arm    <= 1'b0;
                bus.cap_abort  <= 1'b1;
                abort_cnt      <= '0;
                state          <= ABORT;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        seg_last       <= (num_segments == '0) ? '0 : num_segments - seg_w'(1);
                        buf_lat        <= buffer_size;
                        post_lat       <= post_trigger_count;
                        seg_index      <= '0;
                        status_timeout <= 1'b0;
                        status_aborted <= 1'b0;
                        stop_pend      <= 1'b0;
                        busy           <= 1'b1;
                        state          <= WAIT_READY;
                    end
                    WAIT_READY: if (bus.cap_ready) begin
                        bus.cap_arm <= 1'b1;
                        state       <= ARM;
                    end
                    ARM: if (bus.cap_armed) begin
                        bus.cap_arm <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= WAIT_TRIG;
                    end
                    WAIT_TRIG: begin
                        if (bus.cap_triggered) begin
                            state <= WAIT_DONE;
                        end else if (timeout_cycles != '0 &&
                                     tmo_cnt == timeout_cycles - tmo_w'(1)) begin
                            status_timeout <= 1'b1;
                            bus.cap_abort  <= 1'b1;
                            abort_cnt      <= '0;
                            state          <= ABORT;
                        end else begin
                            tmo_cnt <= tmo_cnt + tmo_w'(1);
                        end
                    end
                    WAIT_DONE: if (bus.cap_done) begin
                        bus.dma_addr <= next_addr;
                        bus.dma_len  <= buf_lat;
                        state        <= DRAIN_REQ;
                    end
                    DRAIN_REQ: if (!bus.dma_busy) begin
                        bus.dma_start <= 1'b1;
                        state         <= DRAIN_WAIT;
                    end
                    DRAIN_WAIT: begin
                        if (stop)
                            stop_pend <= 1'b1;
                        // The DMA cannot report busy yet while dma_start is still out.
                        if (!bus.dma_start && !bus.dma_busy) begin
                            if (stop_pend || stop) begin
                                status_aborted <= 1'b1;
                                bus.cap_abort  <= 1'b1;
                                abort_cnt      <= '0;
                                state          <= ABORT;
                            end else begin
                                state <= NEXT;
                            end
                        end
                    end
                    NEXT: begin
                        if (seg_index == seg_last) begin
                            irq   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            seg_index <= seg_index + seg_w'(1);
                            state     <= WAIT_READY;
                        end
                    end
                    ABORT: begin
                        if (bus.cap_ready || abort_cnt == 6'd63) begin
                            bus.cap_abort <= 1'b0;
                            irq           <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            abort_cnt <= abort_cnt + 6'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
